// File: rtl/piso_tx_if.sv
// piso_tx_if: handshake and serial-link bundle for the piso_tx transmitter.
//
// Signals:
//   din        parallel word offered by the producer
//   din_valid  producer has a word on din
//   din_ready  transmitter can take a word this cycle
//   so         serial data bit
//   so_frame   so carries a frame bit this cycle
//   so_last    final bit of the current frame
//   so_par     this cycle carries the parity bit
//   busy       a frame is in flight
//
// Modports: master = producer / link observer, slave = transmitter.
interface piso_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             so;
    logic             so_frame;
    logic             so_last;
    logic             so_par;
    logic             busy;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  so,
        input  so_frame,
        input  so_last,
        input  so_par,
        input  busy
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output so,
        output so_frame,
        output so_last,
        output so_par,
        output busy
    );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter.
//
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one
// bit per clock on bus.so, MSB or LSB first. Words accepted on the final bit
// of a frame follow with no idle gap. All serial outputs are registered;
// din_ready is decoded from registered state only (and forced low in reset).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    piso_tx_if slave modport (din/din_valid/din_ready, so, so_frame,
//          so_last, so_par, busy)
//
// Parameters:
//   WIDTH      data word width (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] sent first, 0: din[0] sent first
//
// Build option:
//   PISO_TX_PARITY_EN  when defined, an even-parity bit follows the data bits
//                      and the frame is WIDTH+1 bits long.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    piso_tx_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    localparam bit PAR_EN = 1'b0;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
    } state_t;
`endif

    // Even parity: XOR of all data bits makes the frame's count of ones even.
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic [CW-1:0]    cnt_r, cnt_s;     // data bits still to send after the current one
    logic             par_r, par_s;
    logic             so_r, so_s;
    logic             frame_r, frame_s;
    logic             last_r, last_s;
    logic             sopar_r, sopar_s;
    logic             busy_r, busy_s;
    logic             ready_s;
    logic             handshake_s;

    // Ready in IDLE and on the final-bit cycle; never while reset is asserted.
    assign ready_s     = rst_n && ((state_r == ST_IDLE) || last_r);
    assign handshake_s = bus.din_valid && ready_s;

    // Next-state and next-output decode; a handshake always starts a new frame.
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        cnt_s   = cnt_r;
        par_s   = par_r;
        so_s    = 1'b0;
        frame_s = 1'b0;
        last_s  = 1'b0;
        sopar_s = 1'b0;
        busy_s  = 1'b0;
        if (handshake_s) begin
            // First bit goes straight to so; the rest wait in the shift register.
            state_s = ST_SHIFT;
            cnt_s   = CW'(WIDTH - 1);
            par_s   = even_parity(bus.din);
            frame_s = 1'b1;
            busy_s  = 1'b1;
            if (MSB_FIRST) begin
                so_s    = bus.din[WIDTH-1];
                shreg_s = {bus.din[WIDTH-2:0], 1'b0};
            end else begin
                so_s    = bus.din[0];
                shreg_s = {1'b0, bus.din[WIDTH-1:1]};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        cnt_s   = cnt_r - CW'(1);
                        frame_s = 1'b1;
                        busy_s  = 1'b1;
                        // Without parity the last data bit closes the frame.
                        last_s  = (cnt_r == CW'(1)) && !PAR_EN;
                        if (MSB_FIRST) begin
                            so_s    = shreg_r[WIDTH-1];
                            shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
                        end else begin
                            so_s    = shreg_r[0];
                            shreg_s = {1'b0, shreg_r[WIDTH-1:1]};
                        end
                    end else begin
`ifdef PISO_TX_PARITY_EN
                        state_s = ST_PARITY;
                        so_s    = par_r;
                        frame_s = 1'b1;
                        last_s  = 1'b1;
                        sopar_s = 1'b1;
                        busy_s  = 1'b1;
`else
                        state_s = ST_IDLE;
`endif
                    end
                end
`ifdef PISO_TX_PARITY_EN
                ST_PARITY: begin
                    state_s = ST_IDLE;
                end
`endif
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered outputs; reset drops any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            par_r   <= 1'b0;
            so_r    <= 1'b0;
            frame_r <= 1'b0;
            last_r  <= 1'b0;
            sopar_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            cnt_r   <= cnt_s;
            par_r   <= par_s;
            so_r    <= so_s;
            frame_r <= frame_s;
            last_r  <= last_s;
            sopar_r <= sopar_s;
            busy_r  <= busy_s;
        end
    end

    assign bus.din_ready = ready_s;
    assign bus.so        = so_r;
    assign bus.so_frame  = frame_r;
    assign bus.so_last   = last_r;
    assign bus.so_par    = sopar_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed self-checking bench for piso_tx with WIDTH=8.
// Two instances share clock and reset: u_msb (MSB_FIRST=1), u_lsb (MSB_FIRST=0).
// Inputs change and outputs are sampled 1 time unit after each rising edge,
// so a sample taken right after edge N shows cycle N+1 of the timing table.
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
    localparam int FL  = 9;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = 8;
    localparam bit PAR = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    piso_tx_if #(.WIDTH(8)) mif ();
    piso_tx_if #(.WIDTH(8)) lif ();

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif.slave)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        mif.din_valid = 1'b1;
        mif.din       = 8'hFF;
        lif.din_valid = 1'b1;
        lif.din       = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({mif.so, mif.so_frame, mif.so_last, mif.so_par, mif.busy, mif.din_ready} !== 6'b0) begin
                errors++;
                $display("FAIL reset_msb[%0d] got %b want 000000", c,
                         {mif.so, mif.so_frame, mif.so_last, mif.so_par, mif.busy, mif.din_ready});
            end
            checks++;
            if ({lif.so, lif.so_frame, lif.so_last, lif.so_par, lif.busy, lif.din_ready} !== 6'b0) begin
                errors++;
                $display("FAIL reset_lsb[%0d] got %b want 000000", c,
                         {lif.so, lif.so_frame, lif.so_last, lif.so_par, lif.busy, lif.din_ready});
            end
        end
        rst_n         = 1'b1;
        mif.din_valid = 1'b0;
        lif.din_valid = 1'b0;
        #1;
        checks++;
        if (mif.din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 1", mif.din_ready);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (mif.so_frame !== 1'b0 || lif.so_frame !== 1'b0 || mif.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_frame[%0d] got frame %b/%b busy %b want 0", c,
                         mif.so_frame, lif.so_frame, mif.busy);
            end
        end
    endtask

    task automatic test_single_msb();
        logic [7:0] w;
        logic       b;
        w = 8'hA5;
        mif.din       = w;
        mif.din_valid = 1'b1;
        tick();
        mif.din_valid = 1'b0;
        mif.din       = 8'h00;   // must not disturb the frame in flight
        for (int k = 0; k < FL; k++) begin
            b = (k < 8) ? w[7-k] : 1'b0;   // 0xA5 has four ones: parity 0
            checks++;
            if (mif.so !== b || mif.so_frame !== 1'b1 || mif.busy !== 1'b1) begin
                errors++;
                $display("FAIL single_bit[%0d] got so %b frame %b busy %b want %b 1 1",
                         k, mif.so, mif.so_frame, mif.busy, b);
            end
            checks++;
            if (mif.so_last !== (k == FL - 1) || mif.so_par !== (PAR && k == 8)) begin
                errors++;
                $display("FAIL single_flags[%0d] got last %b par %b", k, mif.so_last, mif.so_par);
            end
            tick();
        end
        checks++;
        if (mif.so_frame !== 1'b0 || mif.busy !== 1'b0 || mif.din_ready !== 1'b1 || mif.so !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got frame %b busy %b ready %b so %b want 0 0 1 0",
                     mif.so_frame, mif.busy, mif.din_ready, mif.so);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        logic       b;
        int         p;
        mif.din       = 8'h3C;
        mif.din_valid = 1'b1;
        checks++;
        if (mif.din_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_ready got %b want 1", mif.din_ready);
        end
        tick();
        mif.din = 8'hC3;
        for (int i = 0; i < 2 * FL; i++) begin
            p = i % FL;
            w = (i < FL) ? 8'h3C : 8'hC3;
            b = (p < 8) ? w[7-p] : 1'b0;   // both words have four ones
            checks++;
            if (mif.so !== b || mif.so_frame !== 1'b1) begin
                errors++;
                $display("FAIL b2b_bit[%0d] got so %b frame %b want %b 1", i, mif.so, mif.so_frame, b);
            end
            checks++;
            if (mif.din_ready !== (p == FL - 1) || mif.so_last !== (p == FL - 1)) begin
                errors++;
                $display("FAIL b2b_ready[%0d] got ready %b last %b want %b",
                         i, mif.din_ready, mif.so_last, (p == FL - 1));
            end
            tick();
            if (i == FL - 1) begin
                mif.din_valid = 1'b0;
            end
        end
        checks++;
        if (mif.so_frame !== 1'b0 || mif.din_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle got frame %b ready %b want 0 1", mif.so_frame, mif.din_ready);
        end
    endtask

    task automatic test_lsb_first();
        logic b;
        lif.din       = 8'h01;
        lif.din_valid = 1'b1;
        tick();
        lif.din_valid = 1'b0;
        for (int k = 0; k < FL; k++) begin
            b = (k == 0) ? 1'b1 : ((k == 8) ? 1'b1 : 1'b0);   // one data one: parity 1
            checks++;
            if (lif.so !== b || lif.so_frame !== 1'b1 || lif.so_last !== (k == FL - 1)) begin
                errors++;
                $display("FAIL lsb_bit[%0d] got so %b frame %b last %b want %b 1 %b",
                         k, lif.so, lif.so_frame, lif.so_last, b, (k == FL - 1));
            end
            tick();
        end
        checks++;
        if (lif.so_frame !== 1'b0 || lif.busy !== 1'b0) begin
            errors++;
            $display("FAIL lsb_idle got frame %b busy %b want 0 0", lif.so_frame, lif.busy);
        end
    endtask

    task automatic test_parity();
        logic [7:0] words [2];
        logic       pbit  [2];
        logic [7:0] w;
        words[0] = 8'h07; pbit[0] = 1'b1;
        words[1] = 8'h0F; pbit[1] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            w = words[n];
            mif.din       = w;
            mif.din_valid = 1'b1;
            tick();
            mif.din_valid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (mif.so !== w[7-k] || mif.so_par !== 1'b0 || mif.so_last !== (!PAR && k == 7)) begin
                    errors++;
                    $display("FAIL par_data[%0d][%0d] got so %b par %b last %b want %b 0 %b",
                             n, k, mif.so, mif.so_par, mif.so_last, w[7-k], (!PAR && k == 7));
                end
                tick();
            end
            if (PAR) begin
                checks++;
                if ({mif.so, mif.so_par, mif.so_frame, mif.so_last} !== {pbit[n], 3'b111}) begin
                    errors++;
                    $display("FAIL par_bit[%0d] got so/par/frame/last %b want %b",
                             n, {mif.so, mif.so_par, mif.so_frame, mif.so_last}, {pbit[n], 3'b111});
                end
                tick();
            end
            checks++;
            if (mif.so_frame !== 1'b0 || mif.so_par !== 1'b0) begin
                errors++;
                $display("FAIL par_end[%0d] got frame %b par %b want 0 0", n, mif.so_frame, mif.so_par);
            end
        end
    endtask

    task automatic test_mid_reset();
        mif.din       = 8'hFF;
        mif.din_valid = 1'b1;
        tick();
        mif.din_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        checks++;
        if (mif.so !== 1'b1 || mif.so_frame !== 1'b1) begin
            errors++;
            $display("FAIL midrst_bit4 got so %b frame %b want 1 1", mif.so, mif.so_frame);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({mif.so, mif.so_frame, mif.so_last, mif.so_par, mif.busy, mif.din_ready} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_state got %b want 000000",
                     {mif.so, mif.so_frame, mif.so_last, mif.so_par, mif.busy, mif.din_ready});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (mif.din_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready got %b want 1", mif.din_ready);
        end
        for (int c = 0; c < FL; c++) begin
            tick();
            checks++;
            if (mif.so !== 1'b0 || mif.so_frame !== 1'b0 || mif.busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_quiet[%0d] got so %b frame %b busy %b want 0 0 0",
                         c, mif.so, mif.so_frame, mif.busy);
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        mif.din       = 8'h00;
        mif.din_valid = 1'b0;
        lif.din       = 8'h00;
        lif.din_valid = 1'b0;
        test_reset();
        test_single_msb();
        test_back_to_back();
        test_lsb_first();
        test_parity();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parameterised parallel-in/serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on a single serial line, with frame and last-bit strobes. It is the transmit end of the serial shift-register links in this design and drives the `si` input of the downstream shift-register receivers. Back-to-back words are sent with no idle gap. An optional even-parity bit can be compiled in.

## Interface
Parameters:
- WIDTH, 8: data word width in bits; legal range is WIDTH ≥ 2.
- MSB_FIRST, 1: bit order. 1 sends din[WIDTH-1] first; 0 sends din[0] first.

Ports:
- clk, input, 1: the single clock; all logic is on its rising edge.
- rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
- din, input, WIDTH: parallel word; sampled only when the handshake fires.
- din_valid, input, 1: a word is offered on din.
- din_ready, output, 1: the block can accept a word this cycle.
- so, output, 1: serial data (registered).
- so_frame, output, 1: high on every cycle that so carries a frame bit (registered).
- so_last, output, 1: high on the final bit of each frame (registered).
- so_par, output, 1: high on the parity-bit cycle; tied to 0 when parity is compiled out (registered).
- busy, output, 1: a frame is in flight (registered).

## Operation
- Handshake:
  - A word is accepted on a rising edge where din_valid && din_ready.
  - din is captured into a WIDTH-bit shift register and a bit counter, width $clog2(WIDTH+1), is loaded.
  - din_valid may assert independently of din_ready.
  - Once the handshake fires, din may change without affecting the frame in flight.
- States:
  - IDLE: so=0, so_frame=0, busy=0, din_ready=1.
    - On handshake, go to SHIFT.
  - SHIFT: outputs data bit k (k=0..WIDTH-1, in the order set by MSB_FIRST).
    - Shift register moves one position per cycle; counter decrements.
    - After bit WIDTH-1, go to PARITY if parity is compiled in.
    - Otherwise go to SHIFT again if a handshake fired on that cycle, else IDLE.
  - PARITY (compiled in only): outputs the parity bit.
    - Go to SHIFT if a handshake fired on that cycle, else IDLE.
- din_ready is high in IDLE and on the final-bit cycle of a frame, i.e. the cycle where so_last=1. It is low otherwise.
- din_ready is forced to 0 while rst_n=0.
- so_last is high on the final frame bit: data bit WIDTH-1 without parity, the parity bit with parity.
- Simultaneous events:
  - A handshake on the last-bit cycle starts the next frame on the following cycle.
  - so_frame then stays continuously high across both frames.
- Reset:
  - Reset mid-frame abandons the frame.
  - The next cycle shows the full reset state; the in-flight word is dropped and never resent.

## Timing
- Handshake at edge N gives the first data bit on so for cycle N+1.
- Data bit k appears for cycle N+1+k; the final data bit is at cycle N+WIDTH.
- The parity bit, when compiled in, is at cycle N+WIDTH+1.
- Frame length is WIDTH cycles, or WIDTH+1 with parity.
- Back-to-back throughput is one bit per cycle with zero gap cycles.
- busy rises in cycle N+1. It falls in the cycle after the last bit unless a new frame starts.
- Reset values of all registered outputs: so=0, so_frame=0, so_last=0, so_par=0, busy=0. din_ready reads 0 during reset and 1 in the first cycle after reset is released.
- Outputs are combinationally independent of din and din_valid.
  - Exception: din_ready depends on state only.

## Configuration
- PISO_TX_PARITY_EN:
  - Defined:
    - PARITY state exists and the frame is WIDTH+1 bits.
    - The extra bit is even parity: the XOR of all data bits, so the total count of ones in the frame is even.
    - so_par is high on that bit; so_frame and so_last are also high.
  - Undefined:
    - No PARITY state; the frame is WIDTH bits.
    - so_par is held at 0.
    - so_last marks data bit WIDTH-1.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold rst_n=0 for 3 cycles while din_valid=1. Required: so, so_frame, so_last, so_par and busy are 0, din_ready=0, and no frame follows the reset.
- Single word, MSB_FIRST=1: send 0xA5. Required: so reads 1,0,1,0,0,1,0,1 in cycles N+1..N+8, so_frame is high for exactly those 8 cycles, so_last is high only in N+8, and IDLE returns in N+9.
- Back-to-back: hold din_valid with 0x3C then 0xC3. Required: 16 contiguous so_frame cycles carrying 00111100 11000011, with din_ready high only in IDLE and on each so_last cycle.
- LSB first, MSB_FIRST=0: send 0x01. Required: so reads 1 then seven 0s.
- Parity enabled (PISO_TX_PARITY_EN): send 0x07, then 0x0F. Required for 0x07: cycle N+9 shows so=1 with so_par, so_frame and so_last all 1. Required for 0x0F: the parity bit is 0.
- Mid-frame reset: assert rst_n=0 during data bit 4 of 0xFF. Required: the next cycle shows all outputs 0. After release, din_ready=1 and no remaining bits of 0xFF are sent.
